// File: rtl/msx_rom_loader.sv
`timescale 1ns/1ps
// msx_rom_loader
//
// Write-side counterpart to the ROM cartridge mappers. Takes the ROM image byte
// stream from the HPS download channel and buffers it in a small byte FIFO. It
// writes each byte into cartridge RAM through a request/acknowledge port. When
// the image is complete it publishes the number of bytes written as rom_size.
//
// Optional build macro: KONAMI_DETECT_EN adds the konami_hint output. This is a
// heuristic that counts Z80 "LD (nn),A" stores to Konami bank registers.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   dl_start    one-cycle pulse, begins a new image (aborts any image in progress)
//   dl_end      one-cycle pulse, no more bytes follow (only honoured while loading)
//   dl_valid    dl_data holds a byte
//   dl_data     image byte
//   dl_ready    loader accepts the byte this cycle
//   ram_addr    RAM write byte address (BASE_ADDR + write count)
//   ram_din     RAM write data
//   ram_we      write request, held until ram_ack
//   ram_ack     one-cycle pulse, RAM accepted the write
//   rom_size    bytes written for the last completed image
//   load_done   high while a completed image is valid
//   overflow    image exceeded MAX_SIZE, sticky until the next dl_start
//   konami_hint (KONAMI_DETECT_EN only) three or more bank-register stores seen
//   busy        high while loading or flushing
module msx_rom_loader #(
  parameter logic [26:0] BASE_ADDR  = 27'h0000000,
  parameter logic [24:0] MAX_SIZE   = 25'h0100000,
  parameter int unsigned FIFO_DEPTH = 4   // power of two, minimum 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_start,
  input  logic        dl_end,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic [26:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic        ram_ack,
  output logic [24:0] rom_size,
  output logic        load_done,
  output logic        overflow,
`ifdef KONAMI_DETECT_EN
  output logic        konami_hint,
`endif
  output logic        busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e state_q, state_d;

  // FIFO storage and pointers; pointers wrap naturally because depth is 2^PtrW
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;

  logic [24:0] acc_cnt_q;   // bytes kept from the stream (saturates at MAX_SIZE)
  logic [24:0] wr_cnt_q;    // bytes acknowledged by RAM
  logic        ram_we_q;
  logic [26:0] ram_addr_q;
  logic [7:0]  ram_din_q;
  logic        overflow_q;
  logic [24:0] rom_size_q;

  logic fifo_empty, fifo_full;
  logic engine_on, accept, under_max, push, drop, pop, ack_take;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FifoFull);
  assign engine_on  = (state_q == StLoad) || (state_q == StFlush);

  // A byte handshaken in the same cycle as dl_start belongs to neither image.
  assign accept    = (state_q == StLoad) && dl_valid && !fifo_full && !dl_start;
  assign under_max = (acc_cnt_q < MAX_SIZE);
  assign push      = accept && under_max;
  assign drop      = accept && !under_max;

  // Write engine: issue a new request only from an idle request port.
  assign pop      = engine_on && !dl_start && !ram_we_q && !fifo_empty;
  assign ack_take = ram_we_q && ram_ack && !dl_start;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. dl_start from any state (re)starts loading and wins over
  // a simultaneous dl_end.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (dl_start) state_d = StLoad;
      end
      StLoad: begin
        if (dl_start)    state_d = StLoad;
        else if (dl_end) state_d = StFlush;
      end
      StFlush: begin
        if (dl_start)                     state_d = StLoad;
        else if (fifo_empty && !ram_we_q) state_d = StDone;
      end
      StDone: begin
        if (dl_start) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dl_ready  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state_q)
      StLoad: begin
        dl_ready = !fifo_full;
        busy     = 1'b1;
      end
      StFlush: busy      = 1'b1;
      StDone:  load_done = 1'b1;
      default: ;
    endcase
  end

  // FIFO data array, no reset needed: occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= dl_data;
  end

  // ---------------------------------------------------------------------------
  // Datapath: FIFO control, write engine, counters, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      overflow_q <= 1'b0;
      rom_size_q <= '0;
    end else if (dl_start) begin
      // New image: discard buffered bytes and withdraw any pending request.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      ram_we_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + PtrW'(1);
        acc_cnt_q <= acc_cnt_q + 25'd1;
      end

      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        ram_we_q   <= 1'b1;
        ram_addr_q <= BASE_ADDR + {2'b00, wr_cnt_q};
        ram_din_q  <= fifo_mem[rd_ptr_q];
      end else if (ack_take) begin
        ram_we_q <= 1'b0;
        wr_cnt_q <= wr_cnt_q + 25'd1;
      end

      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CntW'(1);
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - CntW'(1);
      end

      if (drop) overflow_q <= 1'b1;

      // wr_cnt_q is final once the flush drains, so latch it on entry to DONE.
      if (state_q == StFlush && state_d == StDone) rom_size_q <= wr_cnt_q;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign overflow = overflow_q;
  assign rom_size = rom_size_q;

`ifdef KONAMI_DETECT_EN
  // Sliding window over kept bytes: win1 is the older, win0 the newer byte.
  // Cleared to 8'h00, which can never complete a match on its own.
  logic [7:0] win0_q, win1_q;
  logic [3:0] match_cnt_q;
  logic       bank_hi, match;

  assign bank_hi = (dl_data == 8'h60) || (dl_data == 8'h80) || (dl_data == 8'hA0);
  assign match   = push && (win1_q == 8'h32) && (win0_q == 8'h00) && bank_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win0_q      <= '0;
      win1_q      <= '0;
      match_cnt_q <= '0;
    end else if (dl_start) begin
      win0_q      <= '0;
      win1_q      <= '0;
      match_cnt_q <= '0;
    end else if (push) begin
      win1_q <= win0_q;
      win0_q <= dl_data;
      if (match && match_cnt_q != 4'hF) match_cnt_q <= match_cnt_q + 4'd1;
    end
  end

  assign konami_hint = (match_cnt_q >= 4'd3);
`endif

endmodule
